logic_unit_arbiter: RTL and testbench

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

---
 rtl/logic_unit_arbiter.sv | 145 ++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter in front of a shared 1-bit logic unit (AND/OR/XOR/NAND).
// Each grant latches the winner's operands, evaluates them, then strobes the result with its owner.
module logic_unit_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   op_a,
  input  logic [NREQ-1:0]   op_b,
  input  logic [2*NREQ-1:0] op_sel,
  output logic [NREQ-1:0]   gnt,
  output logic              res_valid,
  output logic              res,
  output logic [IDW-1:0]    res_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic [IDW-1:0]    last_r;
  logic [IDW-1:0]    winner_r;
  logic [IDW-1:0]    winner_s;
  logic              found_s;
  logic              op_a_r;
  logic              op_b_r;
  logic [1:0]        op_sel_r;
  logic [NREQ-1:0]   gnt_r;
  logic              res_valid_r;
  logic              res_r;
  logic [IDW-1:0]    res_id_r;

  function automatic logic calc_res(input logic [1:0] sel, input logic a, input logic b);
    logic r;
    case (sel)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      2'b11:   r = ~(a & b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Round-robin pick: first requester at or after last+1, wrapping.
  always_comb begin
    winner_s = '0;
    found_s  = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      int idx;
      idx = (int'(last_r) + i) % NREQ;
      if (!found_s && req[idx]) begin
        winner_s = IDW'(idx);
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; arbitration only happens from IDLE.
  always_comb begin
    next_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          next_state_s = ST_EXEC;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_EXEC: next_state_s = ST_RESP;
      ST_RESP: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Grant, operand latch, result and priority pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_r       <= '0;
      res_valid_r <= 1'b0;
      res_r       <= 1'b0;
      res_id_r    <= '0;
      last_r      <= IDW'(NREQ - 1);
      winner_r    <= '0;
      op_a_r      <= 1'b0;
      op_b_r      <= 1'b0;
      op_sel_r    <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          res_valid_r <= 1'b0;
          if (found_s) begin
            gnt_r    <= NREQ'(1'b1) << winner_s;
            winner_r <= winner_s;
            op_a_r   <= op_a[winner_s];
            op_b_r   <= op_b[winner_s];
            op_sel_r <= op_sel[2*winner_s +: 2];
          end else begin
            gnt_r    <= '0;
          end
        end
        ST_EXEC: begin
          gnt_r       <= '0;
          res_r       <= calc_res(op_sel_r, op_a_r, op_b_r);
          res_id_r    <= winner_r;
          res_valid_r <= 1'b1;
        end
        ST_RESP: begin
          gnt_r       <= '0;
          res_valid_r <= 1'b0;
          last_r      <= winner_r;
        end
        default: begin
          gnt_r       <= '0;
          res_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_r;
  assign res_valid = res_valid_r;
  assign res       = res_r;
  assign res_id    = res_id_r;
  assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: expected results queued at drive time,
// popped and compared whenever the DUT strobes res_valid.
module tb_logic_unit_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [7:0] op_sel;
  logic [3:0] gnt;
  logic       res_valid;
  logic       res;
  logic [1:0] res_id;
  logic       busy;

  typedef struct {
    int   id;
    logic r;
  } exp_t;

  exp_t exp_q[$];
  int   check_cnt = 0;
  int   err_cnt   = 0;
  int   model_last = 3;

  logic_unit_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
    .gnt(gnt), .res_valid(res_valid), .res(res), .res_id(res_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Truth table bits indexed by {a,b}.
  function automatic logic ref_res(input logic [1:0] sel, input logic a, input logic b);
    logic [3:0] tt;
    case (sel)
      2'b00:   tt = 4'b1000;
      2'b01:   tt = 4'b1110;
      2'b10:   tt = 4'b0110;
      default: tt = 4'b0111;
    endcase
    return tt[{a, b}];
  endfunction

  function automatic int rr_pick(input int last, input logic [3:0] r);
    for (int i = 1; i <= 4; i++) begin
      if (r[(last + i) % 4]) return (last + i) % 4;
    end
    return -1;
  endfunction

  // Scoreboard monitor and grant/result exclusivity.
  always @(negedge clk) begin
    if (!rst) begin
      check_val("gnt_vs_valid", 32'(res_valid && (gnt != 4'b0000)), 32'd0);
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_res_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_val("res_id", 32'(res_id), 32'(e.id));
          check_val("res", 32'(res), 32'(e.r));
        end
      end
    end
  end

  task automatic do_txn(input logic [3:0] r, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] s, input bit chg);
    int   w;
    exp_t e;
    @(negedge clk);
    req = r; op_a = a; op_b = b; op_sel = s;
    w = rr_pick(model_last, r);
    e.id = w;
    e.r  = ref_res(s[2*w +: 2], a[w], b[w]);
    exp_q.push_back(e);
    @(posedge clk); #1;
    check_val("gnt", 32'(gnt), 32'(1 << w));
    check_val("busy_exec", 32'(busy), 32'd1);
    req = 4'b0000;
    if (chg) begin
      op_a = ~a; op_b = ~b; op_sel = ~s;
    end
    @(posedge clk); #1;
    check_val("res_valid", 32'(res_valid), 32'd1);
    check_val("gnt_resp", 32'(gnt), 32'd0);
    @(posedge clk); #1;
    check_val("res_valid_end", 32'(res_valid), 32'd0);
    check_val("res_id_hold", 32'(res_id), 32'(w));
    check_val("busy_idle", 32'(busy), 32'd0);
    model_last = w;
  endtask

  initial begin
    int order[5];
    rst = 1'b1; req = 4'b0000; op_a = 4'b0000; op_b = 4'b0000; op_sel = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_gnt", 32'(gnt), 32'd0);
    check_val("rst_res_valid", 32'(res_valid), 32'd0);
    check_val("rst_res", 32'(res), 32'd0);
    check_val("rst_res_id", 32'(res_id), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // All four requesting continuously: grants 0,1,2,3,0 every third cycle.
    @(negedge clk);
    req = 4'b1111; op_a = 4'b1010; op_b = 4'b0110; op_sel = 8'b11_10_01_00;
    order = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      exp_t e;
      e.id = order[k];
      e.r  = ref_res(op_sel[2*order[k] +: 2], op_a[order[k]], op_b[order[k]]);
      exp_q.push_back(e);
    end
    for (int c = 0; c <= 14; c++) begin
      @(posedge clk); #1;
      if ((c % 3 == 0) && (c <= 12))
        check_val("rr_gnt", 32'(gnt), 32'(1 << order[c / 3]));
      else
        check_val("rr_gnt_idle", 32'(gnt), 32'd0);
      check_val("rr_res_valid", 32'(res_valid), 32'((c % 3 == 1) && (c <= 13)));
      if (c == 12) req = 4'b0000;
    end
    model_last = 0;

    // Single requester 2, AND of 1,1.
    do_txn(4'b0100, 4'b0100, 4'b0100, 8'h00, 1'b0);

    // Opcode x operand sweep on requester 1, noise on other lanes.
    for (int s = 0; s < 4; s++) begin
      for (int ab = 0; ab < 4; ab++) begin
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] sel;
        a   = 4'($urandom_range(0, 15));
        b   = 4'($urandom_range(0, 15));
        sel = 8'($urandom_range(0, 255));
        a[1] = ab[1];
        b[1] = ab[0];
        sel[3:2] = 2'(s);
        do_txn(4'b0010, a, b, sel, 1'b0);
      end
    end

    // Operands changed after the granting edge must not matter.
    do_txn(4'b1000, 4'b1000, 4'b0000, 8'b10_00_00_00, 1'b1);
    do_txn(4'b0001, 4'b0001, 4'b0001, 8'b00_00_00_11, 1'b1);

    // Reset during EXEC aborts the transaction.
    @(negedge clk);
    req = 4'b0100; op_a = 4'b0100; op_b = 4'b0000; op_sel = 8'h10;
    @(posedge clk); #1;
    check_val("abort_gnt", 32'(gnt), 32'b0100);
    req = 4'b0000;
    #2;
    rst = 1'b1;
    #1;
    check_val("abort_gnt_low", 32'(gnt), 32'd0);
    check_val("abort_valid_low", 32'(res_valid), 32'd0);
    check_val("abort_busy_low", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_last = 3;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_val("abort_no_valid", 32'(res_valid), 32'd0);
    end
    do_txn(4'b0101, 4'b0101, 4'b0100, 8'b00_01_00_01, 1'b0);

    // Wrap from last=1: 0 then 1.
    do_txn(4'b0010, 4'b0010, 4'b0000, 8'b00_00_01_00, 1'b0);
    do_txn(4'b0011, 4'b0001, 4'b0011, 8'b00_00_10_10, 1'b0);
    do_txn(4'b0011, 4'b0010, 4'b0011, 8'b00_00_11_10, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check_val("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
